// File: rtl/systolic_data_setup.sv
// systolic_data_setup: skews activation lanes (lane i delayed by i advances) ahead of a
// weight-stationary array, drives its enable and flushes each tile with zero drain vectors.
module systolic_data_setup #(
    parameter int DATA_WIDTH = 8,
    parameter int SA_LENGTH  = 256
) (
    input  logic                            CLK,
    input  logic                            ASYNC_RST,
    input  logic                            SYNC_RST,
    input  logic                            In_Valid,
    output logic                            In_Ready,
    input  logic                            In_Last,
    input  logic [SA_LENGTH*DATA_WIDTH-1:0] In_Data,
    output logic                            Out_EN,
    output logic [SA_LENGTH*DATA_WIDTH-1:0] Out_Data,
    output logic                            Out_Last,
    output logic                            Busy
);
    localparam int CW   = SA_LENGTH > 2 ? $clog2(SA_LENGTH) : 1;
    localparam int LOAD = SA_LENGTH > 1 ? SA_LENGTH - 2 : 0;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept, advance, last_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = 1'b0;
        In_Ready  = state != DRAIN;
        accept    = In_Valid && In_Ready;
        advance   = accept || state == DRAIN;
        if (state == DRAIN) begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == '0) begin
                state_nxt = IDLE;
                last_nxt  = 1'b1;
            end
        end else if (accept) begin
            if (!In_Last) begin
                state_nxt = STREAM;
            end else if (SA_LENGTH == 1) begin
                state_nxt = IDLE;
                last_nxt  = 1'b1;
            end else begin
                state_nxt = DRAIN;
                cnt_nxt   = CW'(LOAD);
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state    <= IDLE;
            cnt      <= '0;
            Out_EN   <= 1'b0;
            Out_Last <= 1'b0;
        end else if (SYNC_RST) begin
            state    <= IDLE;
            cnt      <= '0;
            Out_EN   <= 1'b0;
            Out_Last <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            Out_EN   <= advance;
            Out_Last <= last_nxt;
        end
    end

    assign Busy = state != IDLE || Out_EN;

    // Lane i is a chain of i+1 registers; drain advances shift zeros in at the head.
    for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] sr [i+1];
        always_ff @(posedge CLK or negedge ASYNC_RST) begin
            if (!ASYNC_RST) begin
                for (int k = 0; k <= i; k++) sr[k] <= '0;
            end else if (SYNC_RST) begin
                for (int k = 0; k <= i; k++) sr[k] <= '0;
            end else if (advance) begin
                sr[0] <= accept ? In_Data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
            end
        end
        assign Out_Data[i*DATA_WIDTH +: DATA_WIDTH] = sr[i];
    end
endmodule

// File: tb/tb_systolic_data_setup.sv
// tb_systolic_data_setup: table, directed and random checks of the skew stage (4 lanes and 1 lane).
module tb_systolic_data_setup;
    localparam int N = 4;
    localparam int W = 8;
    typedef logic [N*W-1:0] vec_t;

    typedef struct {
        bit   v;
        bit   l;
        vec_t d;
        bit   rdy;
        bit   en;
        bit   last;
        bit   busy;
        vec_t q;
    } row_t;

    logic CLK = 0, ASYNC_RST = 0, SYNC_RST = 0;
    logic In_Valid = 0, In_Last = 0, In_Ready, Out_EN, Out_Last, Busy;
    vec_t In_Data = '0, Out_Data;
    logic v1 = 0, l1 = 0, r1, en1, last1, busy1;
    logic [W-1:0] d1 = '0, q1;
    int checks = 0, errors = 0;

    vec_t hist[$];
    int   drain_left;
    bit   tile_open, m_en, m_last;
    row_t tbl[6];

    always #5 CLK = ~CLK;

    systolic_data_setup #(.DATA_WIDTH(W), .SA_LENGTH(N)) dut (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Last(In_Last), .In_Data(In_Data),
        .Out_EN(Out_EN), .Out_Data(Out_Data), .Out_Last(Out_Last), .Busy(Busy)
    );

    systolic_data_setup #(.DATA_WIDTH(W), .SA_LENGTH(1)) dut1 (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST),
        .In_Valid(v1), .In_Ready(r1), .In_Last(l1), .In_Data(d1),
        .Out_EN(en1), .Out_Data(q1), .Out_Last(last1), .Busy(busy1)
    );

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3);
        logic [W-1:0] b0, b1, b2, b3;
        b0 = W'(a0); b1 = W'(a1); b2 = W'(a2); b3 = W'(a3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: lane i shows the vector pushed i advances before the newest one.
    function automatic vec_t exp_data();
        vec_t r, h;
        r = '0;
        for (int i = 0; i < N; i++)
            if (hist.size() > i) begin
                h = hist[hist.size()-1-i];
                r[i*W +: W] = h[i*W +: W];
            end
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        drain_left = 0;
        tile_open  = 0;
        m_en       = 0;
        m_last     = 0;
    endtask

    task automatic model_edge(input bit v, input bit l, input vec_t d);
        bit   adv, nl;
        vec_t push;
        adv = 0; nl = 0; push = '0;
        if (SYNC_RST) begin
            model_reset();
            return;
        end
        if (drain_left > 0) begin
            adv = 1;
            drain_left--;
            nl = drain_left == 0;
        end else if (v) begin
            adv  = 1;
            push = d;
            tile_open = !l;
            if (l) drain_left = N - 1;
        end
        if (adv) hist.push_back(push);
        if (hist.size() > 8) void'(hist.pop_front());
        m_en   = adv;
        m_last = nl;
    endtask

    task automatic check_outputs();
        chk("ready", In_Ready, drain_left == 0);
        chk("en",    Out_EN,   m_en);
        chk("last",  Out_Last, m_last);
        chk("busy",  Busy,     tile_open || drain_left > 0 || m_en);
        chk("data",  Out_Data, exp_data());
    endtask

    task automatic step(input bit v, input bit l, input vec_t d);
        In_Valid = v; In_Last = l; In_Data = d;
        check_outputs();
        model_edge(v, l, d);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bit   ev, el, open1, een, elast;
        logic [W-1:0] eq;
        model_reset();
        #2;
        chk("rst_data", Out_Data, '0);
        chk("rst_en",   Out_EN, 0);
        chk("rst_last", Out_Last, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_rdy",  In_Ready, 1);
        #10 ASYNC_RST = 1;
        @(posedge CLK); #1;

        tbl[0] = '{1, 1, mk(1,2,3,4), 1, 0, 0, 0, '0};
        tbl[1] = '{0, 0, '0, 0, 1, 0, 1, mk(1,0,0,0)};
        tbl[2] = '{0, 0, '0, 0, 1, 0, 1, mk(0,2,0,0)};
        tbl[3] = '{0, 0, '0, 0, 1, 0, 1, mk(0,0,3,0)};
        tbl[4] = '{0, 0, '0, 1, 1, 1, 1, mk(0,0,0,4)};
        tbl[5] = '{0, 0, '0, 1, 0, 0, 0, mk(0,0,0,4)};
        for (int r = 0; r < 6; r++) begin
            In_Valid = tbl[r].v; In_Last = tbl[r].l; In_Data = tbl[r].d;
            chk("tbl_rdy",  In_Ready, tbl[r].rdy);
            chk("tbl_en",   Out_EN,   tbl[r].en);
            chk("tbl_last", Out_Last, tbl[r].last);
            chk("tbl_busy", Busy,     tbl[r].busy);
            chk("tbl_data", Out_Data, tbl[r].q);
            step(tbl[r].v, tbl[r].l, tbl[r].d);
        end

        step(1, 0, mk(1,1,1,1));
        step(1, 0, mk(2,2,2,2));
        step(1, 1, mk(3,3,3,3));
        chk("skew_t3", Out_Data, mk(3,2,1,0));
        step(0, 0, '0);
        chk("skew_t4", Out_Data, mk(0,3,2,1));
        step(0, 0, '0);
        step(0, 0, '0);
        chk("skew_last_t6", Out_Last, 1);
        step(0, 0, '0);

        step(1, 0, mk(5,6,7,8));
        step(0, 0, '0);
        step(0, 0, '0);
        step(1, 1, mk(9,10,11,12));
        for (int i = 0; i < 5; i++) step(0, 0, '0);

        step(1, 1, mk(1,2,3,4));
        for (int i = 0; i < 3; i++) begin
            chk("bp_no99", Out_Data[W-1:0] == 8'd99, 0);
            step(1, 0, mk(99,99,99,99));
        end
        chk("bp_last", Out_Last, 1);
        step(1, 0, mk(99,99,99,99));
        chk("bp_lane0", Out_Data[W-1:0], 99);
        step(1, 1, '0);
        for (int i = 0; i < 4; i++) step(0, 0, '0);

        step(1, 1, mk(5,5,5,5));
        step(0, 0, '0);
        In_Valid = 0;
        #2 ASYNC_RST = 0;
        #1;
        chk("arst_data", Out_Data, '0);
        chk("arst_en",   Out_EN, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_last", Out_Last, 0);
        model_reset();
        #1 ASYNC_RST = 1;
        @(posedge CLK); #1;
        chk("arst_rdy", In_Ready, 1);

        step(1, 1, mk(6,7,8,9));
        step(0, 0, '0);
        SYNC_RST = 1;
        step(0, 0, '0);
        SYNC_RST = 0;
        chk("srst_data", Out_Data, '0);
        chk("srst_rdy",  In_Ready, 1);
        chk("srst_busy", Busy, 0);
        step(0, 0, '0);

        for (int i = 0; i < 400; i++) begin
            SYNC_RST = $urandom_range(0, 49) == 0;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, vec_t'($urandom));
        end
        SYNC_RST = 0;
        step(0, 0, '0);

        v1 = 1; l1 = 1; d1 = 8'hF9;
        chk("n1_rdy0", r1, 1);
        @(posedge CLK); #1;
        v1 = 0; l1 = 0;
        chk("n1_data", q1, 8'hF9);
        chk("n1_en",   en1, 1);
        chk("n1_last", last1, 1);
        chk("n1_rdy1", r1, 1);
        @(posedge CLK); #1;
        chk("n1_en_off", en1, 0);
        chk("n1_hold",   q1, 8'hF9);
        eq = 8'hF9; een = 0; elast = 0; open1 = 0;
        for (int i = 0; i < 40; i++) begin
            ev = $urandom_range(0, 2) != 0;
            el = $urandom_range(0, 2) == 0;
            v1 = ev; l1 = el; d1 = W'($urandom);
            chk("n1r_rdy",  r1, 1);
            chk("n1r_data", q1, eq);
            chk("n1r_en",   en1, een);
            chk("n1r_last", last1, elast);
            chk("n1r_busy", busy1, open1 || een);
            if (ev) begin
                eq = d1; een = 1; elast = el; open1 = !el;
            end else begin
                een = 0; elast = 0;
            end
            @(posedge CLK); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
